// File: rtl/wb_pkg.sv
// Shared load encodings and writeback FSM states.
package wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of a little-endian aligned word.
// Latency: combinational. Backpressure: none.
import wb_pkg::*;

module load_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase

        // Halfword loads use only the upper offset bit.
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            LB:      data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LH:      data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            LW:      data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: owns the regfile write port, tracks one outstanding load, busy scoreboard for decode.
// Latency: one cycle from accept or load return to RegWrite. Backpressure: in_ready low while hold buffer is full, for a second load, or for an ALU write to the pending load rd.
// Build option WB_FWD_EN enables the same-cycle bypass outputs; otherwise they are tied low.
import wb_pkg::*;

module wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_DATA_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_is_load,
    input  logic [2:0]                in_funct3,
    input  logic [1:0]                in_addr_lo,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic [REG_DATA_WIDTH-1:0] dec_rs1,
    input  logic [REG_DATA_WIDTH-1:0] dec_rs2,
    output logic                      stall,
    output logic                      RegWrite,
    output logic [REG_DATA_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic                      fwd1_valid,
    output logic                      fwd2_valid,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

    localparam int NREG = 1 << REG_DATA_WIDTH;

    wb_state_t                 state_q, state_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [REG_DATA_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]                ld_funct3_q, ld_funct3_d;
    logic [1:0]                ld_addr_q, ld_addr_d;
    logic                      hold_vld_q, hold_vld_d;
    logic [REG_DATA_WIDTH-1:0] hold_rd_q, hold_rd_d;
    logic [DATA_WIDTH-1:0]     hold_dat_q, hold_dat_d;
    logic                      wr_en_q, wr_en_d;
    logic [REG_DATA_WIDTH-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_WIDTH-1:0]     wr_dat_q, wr_dat_d;

    logic                      accept;
    logic                      alu_acc;
    logic                      ld_acc;
    logic                      load_ret;
    logic [DATA_WIDTH-1:0]     ld_ext;

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .funct3_i  (ld_funct3_q),
        .addr_lo_i (ld_addr_q),
        .word_i    (mem_rdata),
        .data_o    (ld_ext)
    );

    always_comb begin
        in_ready = 1'b1;
        if (hold_vld_q) begin
            in_ready = 1'b0;
        end else if (state_q == WAIT_LOAD) begin
            // One load in flight; ALU writes to its rd must not overtake it.
            if (in_is_load) begin
                in_ready = 1'b0;
            end else if ((in_rd == ld_rd_q) && (ld_rd_q != '0)) begin
                in_ready = 1'b0;
            end
        end
    end

    assign accept   = in_valid & in_ready;
    assign alu_acc  = accept & ~in_is_load;
    assign ld_acc   = accept & in_is_load;
    assign load_ret = (state_q == WAIT_LOAD) & mem_rvalid;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_addr_d   = ld_addr_q;
        hold_vld_d  = hold_vld_q;
        hold_rd_d   = hold_rd_q;
        hold_dat_d  = hold_dat_q;
        wr_en_d     = 1'b0;
        wr_rd_d     = wr_rd_q;
        wr_dat_d    = wr_dat_q;

        if (ld_acc) begin
            state_d     = WAIT_LOAD;
            ld_rd_d     = in_rd;
            ld_funct3_d = in_funct3;
            ld_addr_d   = in_addr_lo;
            if (in_rd != '0) begin
                busy_d[in_rd] = 1'b1;
            end
        end

        if (load_ret) begin
            state_d         = IDLE;
            busy_d[ld_rd_q] = 1'b0;
            wr_en_d         = (ld_rd_q != '0);
            wr_rd_d         = ld_rd_q;
            wr_dat_d        = ld_ext;
            if (alu_acc) begin
                hold_vld_d = 1'b1;
                hold_rd_d  = in_rd;
                hold_dat_d = in_result;
            end
        end else if (hold_vld_q) begin
            hold_vld_d = 1'b0;
            wr_en_d    = (hold_rd_q != '0);
            wr_rd_d    = hold_rd_q;
            wr_dat_d   = hold_dat_q;
        end else if (alu_acc) begin
            wr_en_d  = (in_rd != '0);
            wr_rd_d  = in_rd;
            wr_dat_d = in_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_addr_q   <= '0;
            hold_vld_q  <= 1'b0;
            hold_rd_q   <= '0;
            hold_dat_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_rd_q     <= '0;
            wr_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_addr_q   <= ld_addr_d;
            hold_vld_q  <= hold_vld_d;
            hold_rd_q   <= hold_rd_d;
            hold_dat_q  <= hold_dat_d;
            wr_en_q     <= wr_en_d;
            wr_rd_q     <= wr_rd_d;
            wr_dat_q    <= wr_dat_d;
        end
    end

    assign stall = (busy_q[dec_rs1] & (dec_rs1 != '0)) |
                   (busy_q[dec_rs2] & (dec_rs2 != '0));

    assign RegWrite = wr_en_q;
    assign rd       = wr_rd_q;
    assign wdata    = wr_dat_q;

`ifdef WB_FWD_EN
    assign fwd1_valid = wr_en_q & (wr_rd_q == dec_rs1) & (wr_rd_q != '0);
    assign fwd2_valid = wr_en_q & (wr_rd_q == dec_rs2) & (wr_rd_q != '0);
    assign fwd_data   = wr_dat_q;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: writeback, load extension, scoreboard, collision, ordering, reset.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        fwd1_valid;
    logic        fwd2_valid;
    logic [31:0] fwd_data;

    int total = 0;
    int bad   = 0;

    wb_stage #(
        .DATA_WIDTH(32),
        .REG_DATA_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_result  (in_result),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .stall      (stall),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .wdata      (wdata),
        .fwd1_valid (fwd1_valid),
        .fwd2_valid (fwd2_valid),
        .fwd_data   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a load, return its word one cycle later, check the extended writeback.
    task automatic do_load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                           input logic [1:0] a, input logic [31:0] word, input logic [31:0] exp);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = r;
        in_funct3  = f3;
        in_addr_lo = a;
        step();
        chk({tag, "_second_load_ready"}, in_ready, 0);
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        step();
        mem_rvalid = 1'b0;
        chk({tag, "_we"}, RegWrite, 1);
        chk({tag, "_rd"}, rd, r);
        chk({tag, "_wdata"}, wdata, exp);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_rd      = '0;
        in_result  = '0;
        in_is_load = 1'b0;
        in_funct3  = '0;
        in_addr_lo = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        dec_rs1    = 5'd7;
        dec_rs2    = 5'd7;

        step();
        step();
        chk("rst_we", RegWrite, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_fwd1", fwd1_valid, 0);
        chk("rst_fwd_data", fwd_data, 0);
        rst = 1'b0;
        step();

        // ALU writeback
        in_valid  = 1'b1;
        in_rd     = 5'd5;
        in_result = 32'hDEADBEEF;
        dec_rs1   = 5'd5;
        dec_rs2   = 5'd6;
        step();
        in_valid = 1'b0;
        chk("alu_we", RegWrite, 1);
        chk("alu_rd", rd, 5);
        chk("alu_wdata", wdata, 32'hDEADBEEF);
`ifdef WB_FWD_EN
        chk("alu_fwd1", fwd1_valid, 1);
        chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);
`else
        chk("alu_fwd1", fwd1_valid, 0);
        chk("alu_fwd_data", fwd_data, 0);
`endif
        chk("alu_fwd2", fwd2_valid, 0);
        step();
        chk("idle_we", RegWrite, 0);

        in_valid  = 1'b1;
        in_rd     = 5'd0;
        in_result = 32'h00001234;
        step();
        in_valid = 1'b0;
        chk("alu_x0_we", RegWrite, 0);

        // Load extension
        do_load("lb",  5'd10, 3'b000, 2'd3, 32'h80FF0000, 32'hFFFFFF80);
        do_load("lbu", 5'd11, 3'b100, 2'd3, 32'h80FF0000, 32'h00000080);
        do_load("lh",  5'd12, 3'b001, 2'd2, 32'h80011234, 32'hFFFF8001);
        do_load("lhu", 5'd13, 3'b101, 2'd1, 32'h1234F00D, 32'h0000F00D);
        do_load("lw",  5'd14, 3'b010, 2'd2, 32'h12345678, 32'h12345678);
        do_load("f3u", 5'd15, 3'b011, 2'd1, 32'h89ABCDEF, 32'h89ABCDEF);

        // Scoreboard and ordering: load x7, ALU to x7 waits behind it
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd7;
        in_funct3  = 3'b010;
        in_addr_lo = 2'd0;
        step();
        in_is_load = 1'b0;
        in_result  = 32'h00000077;
        dec_rs1    = 5'd0;
        dec_rs2    = 5'd7;
        #1;
        chk("sb_stall_rs2", stall, 1);
        chk("ord_alu_same_rd_ready", in_ready, 0);
        dec_rs2 = 5'd0;
        #1;
        chk("sb_rs0_nostall", stall, 0);
        dec_rs1 = 5'd7;
        #1;
        chk("sb_stall_rs1", stall, 1);
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd7;
        step();
        step();
        chk("sb_stall_wait", stall, 1);
        chk("sb_wait_we", RegWrite, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA5555;
        #1;
        chk("sb_stall_retire_cycle", stall, 1);
        step();
        mem_rvalid = 1'b0;
        chk("sb_ret_rd", rd, 7);
        chk("sb_ret_wdata", wdata, 32'hAAAA5555);
        chk("sb_stall_after", stall, 0);
        chk("ord_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("ord_alu_we", RegWrite, 1);
        chk("ord_alu_rd", rd, 7);
        chk("ord_alu_wdata", wdata, 32'h00000077);

        // Collision: load x3 returns as ALU x4 is accepted
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd3;
        in_funct3  = 3'b010;
        step();
        in_is_load = 1'b0;
        in_rd      = 5'd4;
        in_result  = 32'h44444444;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h33333333;
        #1;
        chk("col_ready_before", in_ready, 1);
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        chk("col_load_rd", rd, 3);
        chk("col_load_wdata", wdata, 32'h33333333);
        chk("col_ready_full", in_ready, 0);
        step();
        chk("col_alu_we", RegWrite, 1);
        chk("col_alu_rd", rd, 4);
        chk("col_alu_wdata", wdata, 32'h44444444);
        chk("col_ready_drained", in_ready, 1);

        // Stray response in IDLE
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_we", RegWrite, 0);

        // Reset mid-load, with an ALU write to x9 in flight
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd12;
        step();
        in_is_load = 1'b0;
        in_rd      = 5'd9;
        in_result  = 32'h00000099;
        dec_rs1    = 5'd9;
        dec_rs2    = 5'd12;
        step();
        in_valid = 1'b0;
        chk("x9_rd", rd, 9);
`ifdef WB_FWD_EN
        chk("x9_fwd1", fwd1_valid, 1);
        chk("x9_fwd_data", fwd_data, 32'h00000099);
`else
        chk("x9_fwd1", fwd1_valid, 0);
        chk("x9_fwd_data", fwd_data, 0);
`endif
        chk("rl_stall_before", stall, 1);
        rst = 1'b1;
        #2;
        chk("rl_we", RegWrite, 0);
        chk("rl_rd", rd, 0);
        chk("rl_wdata", wdata, 0);
        chk("rl_stall", stall, 0);
        chk("rl_ready", in_ready, 1);
        chk("rl_fwd1", fwd1_valid, 0);
        step();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12121212;
        step();
        mem_rvalid = 1'b0;
        chk("rl_late_rvalid_we", RegWrite, 0);
        chk("rl_late_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file; sole driver of its write port (RegWrite, rd, write data).
- Accepts ALU results and load requests from the execute/memory stage, waits for variable-latency data-memory read responses, and sign/zero-extends load data.
- Keeps a per-register busy scoreboard so decode can stall on a pending load destination.
- Arbitrates the single write port between ALU results and load returns.

Parameters:
- DATA_WIDTH, 32, register/data width
- REG_DATA_WIDTH, 5, register address width (2**REG_DATA_WIDTH registers)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  execute/memory result valid
- in_ready  output  1  stage can accept in_valid this cycle
- in_rd  input  REG_DATA_WIDTH  destination register
- in_result  input  DATA_WIDTH  ALU result; ignored for loads
- in_is_load  input  1  entry is a load awaiting memory data
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- in_addr_lo  input  2  load byte offset
- mem_rvalid  input  1  data-memory read response valid
- mem_rdata  input  DATA_WIDTH  raw aligned 32-bit word
- dec_rs1  input  REG_DATA_WIDTH  decode source 1
- dec_rs2  input  REG_DATA_WIDTH  decode source 2
- stall  output  1  decode must hold: a source is busy
- RegWrite  output  1  regfile write enable
- rd  output  REG_DATA_WIDTH  regfile write address
- wdata  output  DATA_WIDTH  regfile write data
- fwd1_valid, fwd2_valid  output  1  bypass hit on dec_rs1 / dec_rs2
- fwd_data  output  DATA_WIDTH  bypass data (equals wdata)

Behaviour:
- Reset (async, immediate): RegWrite=0, rd=0, wdata=0, busy=0, hold buffer empty, state IDLE, in_ready=1, stall=0, fwd*=0.
- Transfers occur when in_valid & in_ready on a rising edge.
- RegWrite, rd and wdata are registered: an ALU result accepted at edge N is written to the regfile at edge N+1.
- rd=0 never produces RegWrite=1 and never sets busy.
- States:
  - IDLE: ALU accept writes back. Load accept with rd!=0 latches rd/funct3/addr_lo, sets busy[rd] and goes to WAIT_LOAD. Load with rd=0 still goes to WAIT_LOAD; its data is discarded.
  - WAIT_LOAD: a load presented in this state is refused (in_ready=0). ALU results are still accepted.
  - On mem_rvalid: write back the extended data, clear busy[rd], return to IDLE.
  - mem_rvalid while in IDLE is ignored.
- Load extension (little-endian):
  - Byte lane = addr_lo. Halfword lane = addr_lo[1]; addr_lo[0] is ignored.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
  - Undefined funct3 values behave as LW.
- Write-port collision (mem_rvalid and an ALU accept in the same cycle):
  - The load writes first.
  - The ALU entry goes to a one-entry hold buffer; in_ready=0 while the buffer is full.
  - The buffer drains on the next edge with no load return.
- stall = (busy[dec_rs1] & dec_rs1!=0) | (busy[dec_rs2] & dec_rs2!=0). It is combinational.
- In-order guarantee: an ALU entry whose in_rd equals the pending load rd is refused (in_ready=0) until the load retires.
- Reset mid-WAIT_LOAD: the load is abandoned. The later mem_rvalid arrives in IDLE and is ignored.

Optional Feature:
- WB_FWD_EN defined:
  - fwd1_valid = RegWrite & rd==dec_rs1 & rd!=0; fwd2_valid likewise for dec_rs2.
  - fwd_data = wdata.
  - Purpose: covers same-cycle read of a register being written, where the regfile would otherwise return the old value.
- Undefined: fwd1_valid, fwd2_valid and fwd_data are tied to 0. Ports remain present.

Decomposition:
- Package wb_pkg holds:
  - funct3 load-encoding localparams (LB, LH, LW, LBU, LHU)
  - typedef enum logic {IDLE, WAIT_LOAD} wb_state_t
- Sub-module load_extend is purely combinational: funct3, addr_lo, word -> extended data.
- Scoreboard, hold buffer and FSM stay in wb_stage.

Test Plan:
- ALU writeback: in_rd=5, in_result=0xDEADBEEF at edge N -> RegWrite=1, rd=5, wdata=0xDEADBEEF after edge N+1; in_rd=0 -> RegWrite stays 0.
- Load extension: LB at addr_lo=3, mem_rdata=0x80FF0000 -> wdata=0xFFFFFF80. LBU, same inputs -> 0x00000080. LH at addr_lo=2, mem_rdata=0x8001_1234 -> 0xFFFF8001.
- Scoreboard: load rd=7 accepted, dec_rs2=7 -> stall=1 until the edge with mem_rvalid (3-cycle delay); stall=0 after; dec_rs1=0 never stalls.
- Collision: mem_rvalid with load rd=3 and ALU rd=4 accepted same cycle -> edge 1 writes x3, in_ready=0 that cycle, edge 2 writes x4 with the correct result.
- Ordering/backpressure: in WAIT_LOAD, present a second load -> in_ready=0; present ALU with in_rd equal to the pending load rd -> in_ready=0 until retire.
- Reset mid-load: assert rst in WAIT_LOAD -> all outputs 0, busy clear; subsequent mem_rvalid -> no RegWrite. With WB_FWD_EN: write x9, dec_rs1=9 -> fwd1_valid=1, fwd_data=wdata.
